// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - dual-port (data/instruction) memory responder with fixed latency and one-cycle completion strobe
// Optional MEM_RESP_STATS_EN adds saturating completed-read/write counters.
module mem_responder #(
    parameter int LAT         = 2,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic          owner_i_q, owner_i_d;   // 0 = data side, 1 = instruction side
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   data_q, data_d;
    logic          wr_q, wr_d;
    logic          owner_req;
    logic          done_d, done_i;
    logic [31:0]   rdata;

    logic [31:0]   mem_q [DEPTH_WORDS] = '{default: '0};

    // Upper and byte-lane address bits do not select a word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{daddr[31:AW+2], daddr[1:0], iaddr[31:AW+2], iaddr[1:0]};

    assign owner_req = owner_i_q ? iREN : (dREN | dWEN);

    always_comb begin
        state_d   = state_q;
        owner_i_d = owner_i_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        wr_d      = wr_q;
        case (state_q)
            IDLE: begin
                if (dREN | dWEN) begin
                    owner_i_d = 1'b0;
                    idx_d     = daddr[AW+1:2];
                    data_d    = dstore;
                    wr_d      = dWEN;
                    cnt_d     = 4'd0;
                    state_d   = (LAT == 0) ? DONE : BUSY;
                end else if (iREN) begin
                    owner_i_d = 1'b1;
                    idx_d     = iaddr[AW+1:2];
                    wr_d      = 1'b0;
                    cnt_d     = 4'd0;
                    state_d   = (LAT == 0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                // Owner dropping its request abandons the transaction.
                if (!owner_req) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            owner_i_q <= 1'b0;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            data_q    <= 32'd0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_i_q <= owner_i_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && state_q == DONE && wr_q) begin
            mem_q[idx_q] <= data_q;
        end
    end

    assign rdata  = mem_q[idx_q];
    assign done_d = (state_q == DONE) && !owner_i_q;
    assign done_i = (state_q == DONE) && owner_i_q;
    assign dwait  = !done_d;
    assign iwait  = !done_i;
    assign dload  = (done_d && !wr_q) ? rdata : 32'd0;
    assign iload  = done_i ? rdata : 32'd0;

`ifdef MEM_RESP_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else if (state_q == DONE) begin
            if (wr_q) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = 16'd0;
    assign wr_count = 16'd0;
`endif

endmodule
